stream_mux: RTL and testbench

Registered, flow-controlled N-to-1 multiplexer for streams with a valid/ready handshake. It generalises the combinational bus mux with three selection modes: external select, fixed priority and round-robin. It also adds packet locking, so a multi-beat transfer is never interleaved with another channel. It sits between pipeline producers and shared consumers, for example the debug-unit transmit path and memory-port sharing, wherever several sources compete for one bus.

---
 rtl/stream_mux_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 42 ++++
 rtl/stream_mux.sv | 135 +++++++++++++
 tb/tb_stream_mux.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared constants for the stream multiplexer.
//   DEFAULT_STREAM_MUX_CHANNELS / DEFAULT_STREAM_MUX_BUS_SIZE : default geometry
//   STREAM_MUX_MODE_*                                          : arbitration mode encodings
package stream_mux_pkg;

    localparam int DEFAULT_STREAM_MUX_CHANNELS = 4;
    localparam int DEFAULT_STREAM_MUX_BUS_SIZE = 32;

    localparam int STREAM_MUX_MODE_SELECT   = 0;
    localparam int STREAM_MUX_MODE_PRIORITY = 1;
    localparam int STREAM_MUX_MODE_RR       = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request search: grants the first requesting channel at or above
// `pointer`, wrapping around to channel 0. With pointer tied to 0 it degenerates
// to fixed priority (lowest index wins).
//   request  in  CHANNELS  per-channel request
//   pointer  in  PTR_W     channel where the search starts
//   enable   in  1         zero grant when low
//   grant    out CHANNELS  one-hot grant, or zero when nothing requests
module rr_arbiter #(
    parameter int CHANNELS = 4,
    parameter int PTR_W    = 2
) (
    input  logic [CHANNELS-1:0] request,
    input  logic [PTR_W-1:0]    pointer,
    input  logic                enable,
    output logic [CHANNELS-1:0] grant
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        if (enable) begin
            // Upper segment first: channels at or above the pointer.
            for (int i = 0; i < CHANNELS; i++) begin
                if (!found && request[i] && (i >= int'(pointer))) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
            // Wrapped segment: only reached when nothing at/above the pointer requests,
            // so the lowest requester overall is the correct wrap-around winner.
            for (int i = 0; i < CHANNELS; i++) begin
                if (!found && request[i]) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// Registered, flow-controlled N-to-1 stream multiplexer with packet locking.
// A multi-beat packet (last=0 beats) locks the grant to its channel until the
// beat carrying last=1 is taken, so packets are never interleaved.
//   clk, reset      clock and synchronous active-high reset
//   selector        binary channel select (MODE=select only)
//   in_valid        per-channel valid
//   in_last         per-channel end-of-packet flag
//   data_in         flattened channel data, channel i at [i*BUS_SIZE +: BUS_SIZE]
//   in_ready        per-channel ready, at most one bit high
//   out_valid       output register holds a beat
//   out_ready       consumer accepts the beat
//   data_out        registered data
//   out_last        registered end-of-packet flag
//   out_channel     source channel of the held beat
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int CHANNELS = DEFAULT_STREAM_MUX_CHANNELS,
    parameter int BUS_SIZE = DEFAULT_STREAM_MUX_BUS_SIZE,
    parameter int MODE     = STREAM_MUX_MODE_SELECT,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [SEL_W-1:0]             selector,
    input  logic [CHANNELS-1:0]          in_valid,
    input  logic [CHANNELS-1:0]          in_last,
    input  logic [CHANNELS*BUS_SIZE-1:0] data_in,
    output logic [CHANNELS-1:0]          in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BUS_SIZE-1:0]          data_out,
    output logic                         out_last,
    output logic [SEL_W-1:0]             out_channel
);

    localparam bit IsSelect = (MODE == STREAM_MUX_MODE_SELECT);
    localparam bit IsRr     = (MODE == STREAM_MUX_MODE_RR);

    logic                locked_q;
    logic [SEL_W-1:0]    lock_ch_q;
    logic [SEL_W-1:0]    rr_ptr_q;

    logic [CHANNELS-1:0] sel_grant;
    logic [CHANNELS-1:0] arb_grant;
    logic [CHANNELS-1:0] lock_grant;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    arb_ptr;
    logic                load;

    logic                hs;
    logic [SEL_W-1:0]    hs_ch;
    logic [BUS_SIZE-1:0] hs_data;
    logic                hs_last;
    logic [SEL_W-1:0]    rr_next;

    // External select: out-of-range selector values match no channel.
    always_comb begin
        sel_grant = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sel_grant[i] = in_valid[i] && (int'(selector) == i);
        end
    end

    // Priority mode is the round-robin search with the pointer pinned to 0.
    assign arb_ptr = IsRr ? rr_ptr_q : '0;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .PTR_W    (SEL_W)
    ) u_rr_arbiter (
        .request (in_valid),
        .pointer (arb_ptr),
        .enable  (!IsSelect),
        .grant   (arb_grant)
    );

    // While locked only the owning channel may proceed; if it is idle the mux stalls.
    always_comb begin
        lock_grant = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            lock_grant[i] = in_valid[i] && (int'(lock_ch_q) == i);
        end
    end

    assign grant    = locked_q ? lock_grant : (IsSelect ? sel_grant : arb_grant);
    assign load     = !out_valid || out_ready;
    assign in_ready = (load && !reset) ? grant : '0;

    // in_ready is only ever raised on a valid channel, so any ready bit is a handshake.
    assign hs = |in_ready;

    always_comb begin
        hs_ch   = '0;
        hs_data = '0;
        hs_last = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (in_ready[i]) begin
                hs_ch   = SEL_W'(i);
                hs_data = data_in[i*BUS_SIZE +: BUS_SIZE];
                hs_last = in_last[i];
            end
        end
    end

    assign rr_next = (int'(hs_ch) == CHANNELS - 1) ? '0 : hs_ch + SEL_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            data_out    <= '0;
            out_last    <= 1'b0;
            out_channel <= '0;
            locked_q    <= 1'b0;
            lock_ch_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            if (hs) begin
                out_valid   <= 1'b1;
                data_out    <= hs_data;
                out_last    <= hs_last;
                out_channel <= hs_ch;
                locked_q    <= !hs_last;
                if (!hs_last) begin
                    lock_ch_q <= hs_ch;
                end else begin
                    rr_ptr_q  <= rr_next;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux.sv
// Scoreboard bench for stream_mux: three instances (select, priority, round-robin)
// share stimulus; only the instance selected by `cur` sees valids. The driver pushes
// the expected beat whenever it expects a handshake, and a monitor pops and compares
// every beat the active instance hands to the consumer.
module tb_stream_mux;
    import stream_mux_pkg::*;

    typedef struct packed {
        logic [2:0]  ch;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   selector;
    logic [3:0]   in_valid;
    logic [3:0]   in_last;
    logic [127:0] data_in;
    logic         out_ready;
    int           cur;

    logic [3:0]  v0, v1, v2;
    logic [3:0]  rdy0, rdy1, rdy2;
    logic        ov0, ov1, ov2;
    logic [31:0] do0, do1, do2;
    logic        ol0, ol1, ol2;
    logic [2:0]  oc0;
    logic [1:0]  oc1, oc2;

    logic [3:0]  mon_ready;
    logic        mon_valid;
    logic [31:0] mon_data;
    logic        mon_last;
    logic [2:0]  mon_ch;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    assign v0 = (cur == 0) ? in_valid : 4'b0;
    assign v1 = (cur == 1) ? in_valid : 4'b0;
    assign v2 = (cur == 2) ? in_valid : 4'b0;

    stream_mux #(.CHANNELS(4), .BUS_SIZE(32), .MODE(STREAM_MUX_MODE_SELECT), .SEL_W(3)) u_dut0 (
        .clk(clk), .reset(reset), .selector(selector), .in_valid(v0), .in_last(in_last),
        .data_in(data_in), .in_ready(rdy0), .out_valid(ov0), .out_ready(out_ready),
        .data_out(do0), .out_last(ol0), .out_channel(oc0)
    );

    stream_mux #(.CHANNELS(4), .BUS_SIZE(32), .MODE(STREAM_MUX_MODE_PRIORITY)) u_dut1 (
        .clk(clk), .reset(reset), .selector(selector[1:0]), .in_valid(v1), .in_last(in_last),
        .data_in(data_in), .in_ready(rdy1), .out_valid(ov1), .out_ready(out_ready),
        .data_out(do1), .out_last(ol1), .out_channel(oc1)
    );

    stream_mux #(.CHANNELS(4), .BUS_SIZE(32), .MODE(STREAM_MUX_MODE_RR)) u_dut2 (
        .clk(clk), .reset(reset), .selector(selector[1:0]), .in_valid(v2), .in_last(in_last),
        .data_in(data_in), .in_ready(rdy2), .out_valid(ov2), .out_ready(out_ready),
        .data_out(do2), .out_last(ol2), .out_channel(oc2)
    );

    always_comb begin
        mon_ready = rdy2;
        mon_valid = ov2;
        mon_data  = do2;
        mon_last  = ol2;
        mon_ch    = {1'b0, oc2};
        if (cur == 0) begin
            mon_ready = rdy0;
            mon_valid = ov0;
            mon_data  = do0;
            mon_last  = ol0;
            mon_ch    = oc0;
        end else if (cur == 1) begin
            mon_ready = rdy1;
            mon_valid = ov1;
            mon_data  = do1;
            mon_last  = ol1;
            mon_ch    = {1'b0, oc1};
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every beat taken by the consumer must match the head of the scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (mon_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got ch %0d data 0x%0h, required no beat (t=%0t)",
                         mon_ch, mon_data, $time);
            end else begin
                e = exp_q.pop_front();
                check("beat_channel", 64'(mon_ch), 64'(e.ch));
                check("beat_data", 64'(mon_data), 64'(e.data));
                check("beat_last", 64'(mon_last), 64'(e.last));
            end
        end
    end

    // One cycle of stimulus: apply valids/lasts, check the expected grant (g<0 = none),
    // record the beat that must later emerge, then advance past the clock edge.
    task automatic drive(input logic [3:0] v, input logic [3:0] l, input int g,
                         input string name);
        beat_t e;
        in_valid = v;
        in_last  = l;
        @(negedge clk);
        check(name, 64'(mon_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        if (g >= 0) begin
            e.ch   = 3'(g);
            e.data = 32'(data_in >> (32 * g));
            e.last = l[g[1:0]];
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        selector  = 3'd0;
        in_valid  = 4'hF;
        in_last   = 4'hF;
        data_in   = {32'd4, 32'd3, 32'd2, 32'd1};
        cur       = 2;

        // Reset state, with every channel requesting.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 64'(mon_ready), 64'd0);
        check("reset_out_valid", 64'(mon_valid), 64'd0);
        check("reset_data_out", 64'(mon_data), 64'd0);
        check("reset_out_last", 64'(mon_last), 64'd0);
        check("reset_out_channel", 64'(mon_ch), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Round-robin over all-valid single-beat packets: 0,1,2,3,0.
        drive(4'hF, 4'hF, 0, "rr_grant0");
        check("rr_first_valid", 64'(mon_valid), 64'd1);
        for (int i = 1; i < 5; i++) drive(4'hF, 4'hF, i % 4, "rr_grant");
        drive(4'h0, 4'h0, -1, "rr_idle");

        // Fixed priority: channel 1 beats channel 3 until it drops.
        cur = 1;
        for (int i = 0; i < 3; i++) drive(4'b1010, 4'hF, 1, "prio_low_wins");
        for (int i = 0; i < 2; i++) drive(4'b1000, 4'hF, 3, "prio_ch3");
        drive(4'h0, 4'h0, -1, "prio_idle");

        // Packet lock (rr_ptr is 1): ch2 three beats with a 2-cycle gap, ch0 waits.
        cur = 2;
        drive(4'b0101, 4'b0001, 2, "lock_beat1");
        drive(4'b0101, 4'b0001, 2, "lock_beat2");
        drive(4'b0001, 4'b0001, -1, "lock_gap1");
        check("lock_gap_out_valid", 64'(mon_valid), 64'd0);
        drive(4'b0001, 4'b0001, -1, "lock_gap2");
        drive(4'b0101, 4'b0101, 2, "lock_beat3");
        drive(4'b0001, 4'b0001, 0, "lock_release");
        drive(4'h0, 4'h0, -1, "lock_idle");

        // Backpressure (rr_ptr is 1): hold 0xDEADBEEF for 5 cycles.
        data_in[63:32] = 32'hDEADBEEF;
        out_ready = 1'b0;
        drive(4'b0010, 4'b0010, 1, "bp_load");
        data_in[63:32] = 32'h11111111;
        in_valid = 4'b0100;
        in_last  = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(mon_ready), 64'd0);
            check("bp_out_valid", 64'(mon_valid), 64'd1);
            check("bp_data_stable", 64'(mon_data), 64'hDEADBEEF);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drive(4'b0100, 4'b0100, 2, "bp_resume");
        check("bp_next_valid", 64'(mon_valid), 64'd1);
        drive(4'h0, 4'h0, -1, "bp_idle");

        // External select: out-of-range selector, then a selector change mid-packet.
        cur = 0;
        selector = 3'd5;
        drive(4'hF, 4'hF, -1, "sel_out_of_range");
        drive(4'hF, 4'hF, -1, "sel_out_of_range");
        check("sel_oor_out_valid", 64'(mon_valid), 64'd0);
        selector = 3'd1;
        drive(4'b0110, 4'b0000, 1, "sel_ch1_first");
        selector = 3'd2;
        drive(4'b0110, 4'b0000, 1, "sel_locked");
        drive(4'b0110, 4'b0010, 1, "sel_ch1_last");
        drive(4'b0100, 4'b0100, 2, "sel_ch2");
        drive(4'h0, 4'h0, -1, "sel_idle");

        // Reset mid-packet with a held beat (rr_ptr is 3, ch1 gets locked).
        cur = 2;
        out_ready = 1'b0;
        in_valid  = 4'b0010;
        in_last   = 4'b0000;
        @(negedge clk);
        check("rst_mid_grant", 64'(mon_ready), 64'b0010);
        @(posedge clk);
        #1;
        check("rst_mid_held", 64'(mon_valid), 64'd1);
        reset    = 1'b1;
        in_valid = 4'b1001;
        in_last  = 4'b1001;
        @(negedge clk);
        check("rst_in_ready", 64'(mon_ready), 64'd0);
        @(posedge clk);
        #1;
        check("rst_out_valid", 64'(mon_valid), 64'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        drive(4'b1001, 4'b1001, 0, "rst_rearb");
        drive(4'h0, 4'h0, -1, "rst_idle");

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
